// File: rtl/apb_uart_pkg.sv
// Shared APB UART types: register views, TX sequencer state encoding and the frame parity helper.
package apb_uart_pkg;

   localparam int unsigned DATA_BITS     = 8;
   localparam logic [2:0]  LAST_DATA_IDX = 3'(DATA_BITS - 1);

   typedef struct packed {
      logic extra_stop;
      logic parity_type;
      logic parity_en;
   } uart_cfg_t;

   typedef struct packed {
      logic clk_en;
   } uart_ctrl_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_tx_state_e;

   // Even parity is the XOR of the data bits; odd parity is its inverse.
   function automatic logic frame_parity(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter for the UART transmitter: counts 0..div_i and flags the last cycle of each bit,
// plus a one-cycle lookahead of that flag so downstream strobes can be registered.
module uart_baud_counter #(
   parameter int unsigned DIV_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   output logic                 bit_end_o,
   output logic                 bit_end_next_o
);

   logic [DIV_WIDTH-1:0] cnt_r;
   logic [DIV_WIDTH-1:0] cnt_next_s;

   // Comparing against div_i itself keeps an all-ones divider from wrapping the counter.
   assign bit_end_o = (cnt_r == div_i);

   // Next count: restart on clear or at the end of a bit, otherwise advance.
   always_comb begin
      cnt_next_s = {DIV_WIDTH{1'b0}};
      if (clear_i || bit_end_o) begin
         cnt_next_s = {DIV_WIDTH{1'b0}};
      end else begin
         cnt_next_s = cnt_r + DIV_WIDTH'(1);
      end
   end

   assign bit_end_next_o = (cnt_next_s == div_i);

   // Bit-period counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_r <= {DIV_WIDTH{1'b0}};
      end else begin
         cnt_r <= cnt_next_s;
      end
   end

endmodule

// File: rtl/uart_tx_sequencer.sv
// APB UART transmit sequencer: pops TX FIFO bytes and serialises start, data, parity and stop bits.
// Defining UART_TX_BREAK_EN adds a break_i input that holds the idle line low.
module uart_tx_sequencer
   import apb_uart_pkg::*;
#(
   parameter int unsigned DIV_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clk_en_i,
`ifdef UART_TX_BREAK_EN
   input  logic                 break_i,
`endif
   input  logic [DIV_WIDTH-1:0] clk_div_i,
   input  logic                 parity_en_i,
   input  logic                 parity_type_i,
   input  logic                 extra_stop_i,
   input  logic [7:0]           fifo_data_i,
   input  logic                 fifo_valid_i,
   output logic                 fifo_ready_o,
   output logic                 tx_o,
   output logic                 busy_o,
   output logic                 frame_done_o
);

   uart_tx_state_e       state_r;
   uart_tx_state_e       state_next_s;
   logic [2:0]           bit_idx_r;
   logic [2:0]           bit_idx_next_s;
   logic                 stop_idx_r;
   logic                 stop_idx_next_s;
   logic [7:0]           data_r;
   uart_cfg_t            cfg_r;
   logic [DIV_WIDTH-1:0] div_r;
   logic                 tx_r;
   logic                 busy_r;
   logic                 frame_done_r;
   logic                 tx_next_s;
   logic                 busy_next_s;
   logic                 frame_done_next_s;
   logic                 bit_end_s;
   logic                 bit_end_next_s;
   logic                 clear_s;
   logic                 frame_last_s;
   logic                 fifo_ready_s;
   logic                 pop_s;
   logic                 line_break_s;
   logic                 idle_level_s;

`ifdef UART_TX_BREAK_EN
   logic break_r;

   // Previous-cycle break request, so popping resumes one cycle after release.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         break_r <= 1'b0;
      end else begin
         break_r <= break_i;
      end
   end

   assign line_break_s = break_i | break_r;
   assign idle_level_s = ~break_i;
`else
   assign line_break_s = 1'b0;
   assign idle_level_s = 1'b1;
`endif

   // Last cycle of the final stop bit: the only mid-frame point where a new byte may be taken.
   assign frame_last_s = (state_r == STOP) && (stop_idx_r == cfg_r.extra_stop) && bit_end_s;
   assign fifo_ready_s = !rst_i && clk_en_i && !line_break_s && ((state_r == IDLE) || frame_last_s);
   assign pop_s        = fifo_valid_i && fifo_ready_s;
   assign clear_s      = (state_r == IDLE) || pop_s;

   uart_baud_counter #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_baud (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .clear_i        (clear_s),
      .div_i          (div_r),
      .bit_end_o      (bit_end_s),
      .bit_end_next_o (bit_end_next_s)
   );

   // Next-state logic, plus the values the registered outputs take in that next state.
   always_comb begin
      state_next_s      = state_r;
      bit_idx_next_s    = bit_idx_r;
      stop_idx_next_s   = stop_idx_r;
      tx_next_s         = 1'b1;
      busy_next_s       = 1'b0;
      frame_done_next_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (pop_s) begin
               state_next_s = START;
            end else begin
               state_next_s = IDLE;
            end
         end
         START: begin
            if (bit_end_s) begin
               state_next_s   = DATA;
               bit_idx_next_s = 3'd0;
            end else begin
               state_next_s = START;
            end
         end
         DATA: begin
            if (bit_end_s && (bit_idx_r == LAST_DATA_IDX)) begin
               stop_idx_next_s = 1'b0;
               if (cfg_r.parity_en) begin
                  state_next_s = PARITY;
               end else begin
                  state_next_s = STOP;
               end
            end else if (bit_end_s) begin
               bit_idx_next_s = bit_idx_r + 3'd1;
            end else begin
               state_next_s = DATA;
            end
         end
         PARITY: begin
            if (bit_end_s) begin
               state_next_s    = STOP;
               stop_idx_next_s = 1'b0;
            end else begin
               state_next_s = PARITY;
            end
         end
         STOP: begin
            if (frame_last_s && pop_s) begin
               state_next_s = START;
            end else if (frame_last_s) begin
               state_next_s = IDLE;
            end else if (bit_end_s) begin
               stop_idx_next_s = 1'b1;
            end else begin
               state_next_s = STOP;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase

      case (state_next_s)
         IDLE:    tx_next_s = idle_level_s;
         START:   tx_next_s = 1'b0;
         DATA:    tx_next_s = data_r[bit_idx_next_s];
         PARITY:  tx_next_s = frame_parity(data_r, cfg_r.parity_type);
         STOP:    tx_next_s = 1'b1;
         default: tx_next_s = 1'b1;
      endcase

      busy_next_s       = (state_next_s != IDLE);
      frame_done_next_s = (state_next_s == STOP) && (stop_idx_next_s == cfg_r.extra_stop)
                          && bit_end_next_s;
   end

   // State register and registered line outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= IDLE;
         bit_idx_r    <= 3'd0;
         stop_idx_r   <= 1'b0;
         tx_r         <= 1'b1;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         bit_idx_r    <= bit_idx_next_s;
         stop_idx_r   <= stop_idx_next_s;
         tx_r         <= tx_next_s;
         busy_r       <= busy_next_s;
         frame_done_r <= frame_done_next_s;
      end
   end

   // Frame registers: snapshot of byte and configuration taken at the pop, so mid-frame writes wait.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_r <= 8'h00;
         cfg_r  <= uart_cfg_t'(3'b000);
         div_r  <= {DIV_WIDTH{1'b0}};
      end else if (pop_s) begin
         data_r            <= fifo_data_i;
         cfg_r.parity_en   <= parity_en_i;
         cfg_r.parity_type <= parity_type_i;
         cfg_r.extra_stop  <= extra_stop_i;
         div_r             <= clk_div_i;
      end
   end

   assign fifo_ready_o = fifo_ready_s;
   assign tx_o         = tx_r;
   assign busy_o       = busy_r;
   assign frame_done_o = frame_done_r;

endmodule
